// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad front end: operand-entry phases and
// active-low 7-segment patterns, bit order {dp,g,f,e,d,c,b,a}.
package keypad_pkg;

  localparam int unsigned PHASE_W = 2;
  localparam int unsigned SEG_W   = 8;

  typedef enum logic [PHASE_W-1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    DONE    = 2'd2
  } phase_t;

  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  // Hex glyphs, dp off; same patterns as the scanner uses.
  localparam logic [SEG_W-1:0] SEG_0 = 8'hC0;
  localparam logic [SEG_W-1:0] SEG_1 = 8'hF9;
  localparam logic [SEG_W-1:0] SEG_2 = 8'hA4;
  localparam logic [SEG_W-1:0] SEG_3 = 8'hB0;
  localparam logic [SEG_W-1:0] SEG_4 = 8'h99;
  localparam logic [SEG_W-1:0] SEG_5 = 8'h92;
  localparam logic [SEG_W-1:0] SEG_6 = 8'h82;
  localparam logic [SEG_W-1:0] SEG_7 = 8'hF8;
  localparam logic [SEG_W-1:0] SEG_8 = 8'h80;
  localparam logic [SEG_W-1:0] SEG_9 = 8'h90;
  localparam logic [SEG_W-1:0] SEG_A = 8'h88;
  localparam logic [SEG_W-1:0] SEG_B = 8'h83;
  localparam logic [SEG_W-1:0] SEG_C = 8'hC6;
  localparam logic [SEG_W-1:0] SEG_D = 8'hA1;
  localparam logic [SEG_W-1:0] SEG_E = 8'h86;
  localparam logic [SEG_W-1:0] SEG_F = 8'h8E;

endpackage

// File: rtl/keypad_operand_entry_hex_to_7seg.sv
// Combinational hex to active-low 7-segment decoder, dp always off.
// Ports: hex (4-bit digit in), seg_c (8-bit {dp,g,f,e,d,c,b,a} out).
module hex_to_7seg
  import keypad_pkg::*;
(
  input  logic [3:0]       hex,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (hex)
      4'h0: seg_c = SEG_0;
      4'h1: seg_c = SEG_1;
      4'h2: seg_c = SEG_2;
      4'h3: seg_c = SEG_3;
      4'h4: seg_c = SEG_4;
      4'h5: seg_c = SEG_5;
      4'h6: seg_c = SEG_6;
      4'h7: seg_c = SEG_7;
      4'h8: seg_c = SEG_8;
      4'h9: seg_c = SEG_9;
      4'hA: seg_c = SEG_A;
      4'hB: seg_c = SEG_B;
      4'hC: seg_c = SEG_C;
      4'hD: seg_c = SEG_D;
      4'hE: seg_c = SEG_E;
      4'hF: seg_c = SEG_F;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: accepts one hex digit per physical key press
// (release detected by quiet scans), shifts digits into a 4-digit entry,
// commits operand A then B with the enter button and drives four
// active-low 7-segment digits.
// Ports: clk, rst_n (sync, active-low); key_valid/key_code/scan_tick from
// the scanner; enter_btn/clear_btn debounced levels; num1/num2 committed
// operands; operands_valid one-cycle pulse on num2 commit; phase FSM state;
// digit_cnt digits held; out_7seg four digits, newest in [7:0].
module keypad_operand_entry
  import keypad_pkg::*;
#(
  parameter int unsigned RELEASE_SCANS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [3:0]   key_code,
  input  logic         scan_tick,
  input  logic         enter_btn,
  input  logic         clear_btn,
  output logic [15:0]  num1,
  output logic [15:0]  num2,
  output logic         operands_valid,
  output logic [1:0]   phase,
  output logic [2:0]   digit_cnt,
  output logic [31:0]  out_7seg
);

  localparam int unsigned ENTRY_W = 16;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned REL_W   = 4;
  localparam int unsigned NDIG    = 4;

  phase_t               state_q, state_n;
  logic [ENTRY_W-1:0]   entry_q, entry_n;
  logic [CNT_W-1:0]     cnt_q, cnt_n;
  logic [ENTRY_W-1:0]   num1_q, num1_n;
  logic [ENTRY_W-1:0]   num2_q, num2_n;
  logic                 ov_q, ov_n;
  logic                 locked_q, locked_n;
  logic [REL_W-1:0]     rel_q, rel_n;
  logic                 enter_prev_q, clear_prev_q;
  logic [NDIG*SEG_W-1:0] seg_q, seg_n;

  logic enter_rise_c, clear_rise_c, key_new_c;

  assign enter_rise_c = enter_btn & ~enter_prev_q;
  assign clear_rise_c = clear_btn & ~clear_prev_q;
  assign key_new_c    = key_valid & ~locked_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ENTER_A;
    else        state_q <= state_n;
  end

  // Next state and entry/operand updates; priority clear > enter > digit
  always_comb begin
    state_n = state_q;
    entry_n = entry_q;
    cnt_n   = cnt_q;
    num1_n  = num1_q;
    num2_n  = num2_q;
    ov_n    = 1'b0;
    if (clear_rise_c) begin
      case (state_q)
        ENTER_A: begin
          entry_n = '0;
          cnt_n   = '0;
        end
        ENTER_B: begin
          if (cnt_q != '0) begin
            entry_n = '0;
            cnt_n   = '0;
          end else begin
            state_n = ENTER_A;
          end
        end
        DONE: begin
          num1_n  = '0;
          num2_n  = '0;
          entry_n = '0;
          cnt_n   = '0;
          state_n = ENTER_A;
        end
        default: state_n = ENTER_A;
      endcase
    end else if (enter_rise_c) begin
      if (cnt_q != '0) begin
        case (state_q)
          ENTER_A: begin
            num1_n  = entry_q;
            entry_n = '0;
            cnt_n   = '0;
            state_n = ENTER_B;
          end
          ENTER_B: begin
            num2_n  = entry_q;
            ov_n    = 1'b1;
            entry_n = '0;
            cnt_n   = '0;
            state_n = DONE;
          end
          default: state_n = state_q;
        endcase
      end
    end else if (key_new_c) begin
      // A digit in DONE starts a fresh operand A; a full entry drops it
      if (state_q == DONE) begin
        entry_n = {12'h000, key_code};
        cnt_n   = CNT_W'(1);
        state_n = ENTER_A;
      end else if (cnt_q != CNT_W'(NDIG)) begin
        entry_n = {entry_q[ENTRY_W-5:0], key_code};
        cnt_n   = cnt_q + CNT_W'(1);
      end
    end
  end

  // Press lock: any key_valid (even a discarded one) locks and restarts the
  // quiet-scan count; the lock drops after RELEASE_SCANS quiet scans
  always_comb begin
    locked_n = locked_q;
    rel_n    = rel_q;
    if (key_valid) begin
      locked_n = 1'b1;
      rel_n    = '0;
    end else if (scan_tick && locked_q) begin
      if (rel_q == REL_W'(RELEASE_SCANS - 1)) begin
        locked_n = 1'b0;
        rel_n    = '0;
      end else begin
        rel_n = rel_q + REL_W'(1);
      end
    end
  end

  // Display: num2 fully lit in DONE, otherwise only held entry digits
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    logic [3:0]       hex_c;
    logic [SEG_W-1:0] dec_c;
    logic             lit_c;

    assign hex_c = (state_q == DONE) ? num2_q[4*i +: 4] : entry_q[4*i +: 4];
    assign lit_c = (state_q == DONE) || (cnt_q > CNT_W'(i));

    hex_to_7seg u_dec (
      .hex   (hex_c),
      .seg_c (dec_c)
    );

    assign seg_n[SEG_W*i +: SEG_W] = lit_c ? dec_c : SEG_BLANK;
  end

  // Datapath registers; button history resets high to mask held buttons
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q      <= '0;
      cnt_q        <= '0;
      num1_q       <= '0;
      num2_q       <= '0;
      ov_q         <= 1'b0;
      locked_q     <= 1'b0;
      rel_q        <= '0;
      enter_prev_q <= 1'b1;
      clear_prev_q <= 1'b1;
      seg_q        <= '1;
    end else begin
      entry_q      <= entry_n;
      cnt_q        <= cnt_n;
      num1_q       <= num1_n;
      num2_q       <= num2_n;
      ov_q         <= ov_n;
      locked_q     <= locked_n;
      rel_q        <= rel_n;
      enter_prev_q <= enter_btn;
      clear_prev_q <= clear_btn;
      seg_q        <= seg_n;
    end
  end

  assign num1           = num1_q;
  assign num2           = num2_q;
  assign operands_valid = ov_q;
  assign phase          = state_q;
  assign digit_cnt      = cnt_q;
  assign out_7seg       = seg_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
module tb_keypad_operand_entry;

  localparam int unsigned RS = 3;
  localparam logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                      8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                                      8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        scan_tick;
  logic        enter_btn;
  logic        clear_btn;
  logic [15:0] num1, num2;
  logic        operands_valid;
  logic [1:0]  phase;
  logic [2:0]  digit_cnt;
  logic [31:0] out_7seg;

  keypad_operand_entry #(.RELEASE_SCANS(RS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .scan_tick      (scan_tick),
    .enter_btn      (enter_btn),
    .clear_btn      (clear_btn),
    .num1           (num1),
    .num2           (num2),
    .operands_valid (operands_valid),
    .phase          (phase),
    .digit_cnt      (digit_cnt),
    .out_7seg       (out_7seg)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int ov_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: digits kept as a queue, oldest first
  bit          m_valid = 1'b0;
  int          m_phase;
  logic [15:0] m_num1, m_num2;
  bit          m_ov;
  logic [3:0]  m_dig[$];
  bit          m_locked;
  int          m_quiet;
  bit          m_ep, m_cp;
  logic [31:0] m_seg;

  function automatic logic [15:0] entry_val();
    logic [15:0] v = 16'h0;
    foreach (m_dig[k]) v = (v << 4) | 16'(m_dig[k]);
    return v;
  endfunction

  function automatic logic [31:0] disp();
    logic [31:0] r = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      if (m_phase == 2)          r[8*i +: 8] = SEG[m_num2[4*i +: 4]];
      else if (i < m_dig.size()) r[8*i +: 8] = SEG[m_dig[m_dig.size()-1-i]];
    end
    return r;
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] nseg;
    bit er, cr, acc;
    if (!rst_n) begin
      m_valid = 1'b1;
      m_phase = 0; m_num1 = 16'h0; m_num2 = 16'h0; m_ov = 1'b0;
      m_dig.delete();
      m_locked = 1'b0; m_quiet = 0;
      m_ep = 1'b1; m_cp = 1'b1;
      m_seg = 32'hFFFF_FFFF;
    end else if (m_valid) begin
      nseg = disp();
      er = enter_btn && !m_ep;
      cr = clear_btn && !m_cp;
      m_ep = enter_btn;
      m_cp = clear_btn;
      m_ov = 1'b0;
      acc = key_valid && !m_locked;
      if (key_valid) begin
        m_locked = 1'b1;
        m_quiet  = 0;
      end else if (scan_tick && m_locked) begin
        m_quiet++;
        if (m_quiet >= int'(RS)) begin
          m_locked = 1'b0;
          m_quiet  = 0;
        end
      end
      if (cr) begin
        if (m_phase == 0) m_dig.delete();
        else if (m_phase == 1) begin
          if (m_dig.size() > 0) m_dig.delete();
          else m_phase = 0;
        end else begin
          m_num1 = 16'h0; m_num2 = 16'h0; m_phase = 0;
        end
      end else if (er) begin
        if (m_dig.size() > 0 && m_phase == 0) begin
          m_num1 = entry_val(); m_dig.delete(); m_phase = 1;
        end else if (m_dig.size() > 0 && m_phase == 1) begin
          m_num2 = entry_val(); m_dig.delete(); m_phase = 2; m_ov = 1'b1;
        end
      end else if (acc) begin
        if (m_phase == 2) begin
          m_dig.delete(); m_dig.push_back(key_code); m_phase = 0;
        end else if (m_dig.size() < 4) begin
          m_dig.push_back(key_code);
        end
      end
      m_seg = nseg;
    end
  end

  // Compare every output against the model each cycle
  always @(negedge clk) begin
    if (m_valid) begin
      chk("num1", 32'(num1), 32'(m_num1));
      chk("num2", 32'(num2), 32'(m_num2));
      chk("operands_valid", 32'(operands_valid), 32'(m_ov));
      chk("phase", 32'(phase), 32'(m_phase));
      chk("digit_cnt", 32'(digit_cnt), 32'(m_dig.size()));
      chk("out_7seg", out_7seg, m_seg);
      if (operands_valid === 1'b1) ov_seen++;
    end
  end

  task automatic drive(input logic kv, input logic [3:0] kc, input logic st,
                       input logic en, input logic cl);
    key_valid = kv; key_code = kc; scan_tick = st; enter_btn = en; clear_btn = cl;
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code);
    drive(1'b1, code, 1'b1, 1'b0, 1'b0);
    repeat (RS) drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter_press();
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_press();
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int ov_base;
    logic e_lvl, c_lvl;
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0; scan_tick = 1'b0;
    enter_btn = 1'b1; clear_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset num1", 32'(num1), 32'h0);
    chk("reset phase", 32'(phase), 32'h0);
    chk("reset digit_cnt", 32'(digit_cnt), 32'h0);
    chk("reset out_7seg", out_7seg, 32'hFFFF_FFFF);

    // Enter held through reset release must not commit
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("held enter phase", 32'(phase), 32'h0);

    // Hold key 7 for five scans, release, press again
    for (int s = 0; s < 5; s++) begin
      drive(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    end
    chk("hold cnt", 32'(digit_cnt), 32'h1);
    repeat (RS) drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
    chk("release cnt", 32'(digit_cnt), 32'h2);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("hold display", out_7seg, 32'hFFFF_F8F8);
    repeat (RS) drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Operand commit
    clear_press();
    chk("clear A cnt", 32'(digit_cnt), 32'h0);
    press(4'h1); press(4'h2); press(4'hA); press(4'hF);
    enter_press();
    chk("num1 commit", 32'(num1), 32'h12AF);
    chk("phase B", 32'(phase), 32'h1);
    ov_base = ov_seen;
    press(4'h0); press(4'h0); press(4'h3);
    enter_press();
    chk("num2 commit", 32'(num2), 32'h0003);
    chk("phase DONE", 32'(phase), 32'h2);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("done display", out_7seg, 32'hC0C0_C0B0);
    chk("ov pulses", 32'(ov_seen - ov_base), 32'h1);

    clear_press();
    chk("done clear num1", 32'(num1), 32'h0);
    chk("done clear num2", 32'(num2), 32'h0);

    // Overflow
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    chk("overflow cnt", 32'(digit_cnt), 32'h4);
    chk("overflow display", out_7seg, 32'hF9A4_B099);
    enter_press();
    chk("overflow num1", 32'(num1), 32'h1234);

    // Clear paths in ENTER_B
    press(4'h6); press(4'h7);
    clear_press();
    chk("clear B cnt", 32'(digit_cnt), 32'h0);
    chk("clear B phase", 32'(phase), 32'h1);
    clear_press();
    chk("second clear phase", 32'(phase), 32'h0);

    // Enter and clear edges together
    press(4'h8);
    drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("simul cnt", 32'(digit_cnt), 32'h0);
    chk("simul num1", 32'(num1), 32'h1234);

    // key_valid with scan_tick while locked restarts the release count
    drive(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'h4, 1'b0, 1'b0, 1'b0);
    chk("lock restart cnt", 32'(digit_cnt), 32'h1);
    repeat (RS) drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'h4, 1'b1, 1'b0, 1'b0);
    chk("relock cnt", 32'(digit_cnt), 32'h2);
    repeat (RS) drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Reset mid-entry
    press(4'h5);
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("midrst num1", 32'(num1), 32'h0);
    chk("midrst cnt", 32'(digit_cnt), 32'h0);
    chk("midrst phase", 32'(phase), 32'h0);
    chk("midrst seg", out_7seg, 32'hFFFF_FFFF);
    rst_n = 1'b1;

    // Random traffic
    e_lvl = 1'b0; c_lvl = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 7) == 0) e_lvl = ~e_lvl;
      if ($urandom_range(0, 19) == 0) c_lvl = ~c_lvl;
      drive(($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 2) == 0), e_lvl, c_lvl);
    end
    rst_n = 1'b1;
    repeat (4) drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_operand_entry.md
# keypad_operand_entry

Downstream stage of the 4x4 keypad scanner. It takes the scanner's per-scan key code and accepts exactly one digit per physical press, using release detection. Accepted hex digits are shifted into a 4-digit entry register, and two 16-bit operands are committed in sequence with an enter button. The block drives the four active-low 7-segment digits with the entry in progress.

## Interface
Parameters:
- RELEASE_SCANS, 3: consecutive scan periods with no key seen before the key counts as released (range 1–15).

Ports:
- clk  in  1  system clock (50 MHz board clock).
- rst_n  in  1  synchronous, active-low reset.
- key_valid  in  1  one-cycle pulse from the scanner. A key was detected this scan.
- key_code  in  4  hex code of the detected key. Valid only when key_valid=1.
- scan_tick  in  1  one-cycle pulse once per complete 4-column scan.
- enter_btn  in  1  commit button, level. Already synchronised and debounced.
- clear_btn  in  1  clear button, level. Already synchronised and debounced.
- num1  out  16  committed operand A.
- num2  out  16  committed operand B.
- operands_valid  out  1  one-cycle pulse when num2 is committed.
- phase  out  2  current FSM state encoding.
- digit_cnt  out  3  digits held in the entry register (0–4).
- out_7seg  out  32  four digits of 8 bits each, {dp,g,f,e,d,c,b,a}, active-low. Newest digit in [7:0].

## Operation
- Press acceptance:
  - A `locked` flag is set when a key_valid pulse is accepted.
  - While locked, key_valid is ignored and resets the release counter.
  - Each scan_tick without key_valid increments the counter. At RELEASE_SCANS the flag clears.
  - If key_valid and scan_tick occur in the same cycle, key_valid wins and the counter resets.
- Button edges:
  - Rising-edge detect on enter_btn and clear_btn.
  - The previous-value registers reset to 1, so a button held through reset produces no edge.
- Entry register update on an accepted digit: entry <= {entry[11:0], key_code} and digit_cnt+1.
  - When digit_cnt=4, further digits are dropped; entry and count are unchanged.
- FSM states are ENTER_A=0, ENTER_B=1, DONE=2.
  - ENTER_A + enter with digit_cnt>0: num1<=entry, entry/count cleared, go to ENTER_B.
  - ENTER_B + enter with digit_cnt>0: num2<=entry, operands_valid pulses, entry/count cleared, go to DONE.
  - Enter with digit_cnt=0 is ignored in every state.
  - Clear in ENTER_A/ENTER_B with digit_cnt>0 clears entry/count only.
  - Clear in ENTER_B with digit_cnt=0 returns to ENTER_A.
  - Clear in DONE: num1=num2=0, go to ENTER_A.
  - Accepted digit in DONE: entry={12'h0,key_code}, count=1, go to ENTER_A. num1/num2 are kept until overwritten.
- Same-cycle priority: clear > enter > digit. A lower-priority event in the same cycle is discarded; a discarded digit still sets locked.
- Display:
  - Digit i (i=0 newest) shows entry[4i+3:4i] when i<digit_cnt, otherwise blank (8'hFF).
  - In DONE the display shows num2, all four digits lit.
  - dp is always off (1).

## Timing
- Reset values:
  - num1=num2=0, operands_valid=0, phase=ENTER_A, digit_cnt=0.
  - out_7seg=32'hFFFF_FFFF, locked=0, release counter=0, entry=0.
- Accepted key_valid at edge t: entry and digit_cnt update at t+1; out_7seg (registered) updates at t+2.
- Enter edge first sampled at t: num1/num2/phase update at t+1. operands_valid is high for exactly the cycle after t+1's edge (one cycle).
- Release: key_valid is accepted no earlier than RELEASE_SCANS scan_ticks after the last key_valid.
- Reset asserted mid-entry takes effect at the next edge and overrides every other input in that cycle.

## Structure
- Shared package `keypad_pkg`:
  - phase enumeration (ENTER_A/ENTER_B/DONE).
  - SEG_BLANK=8'hFF.
  - The active-low hex segment constants 0–F, the same patterns used by the scanner.
- One sub-module, `hex_to_7seg`: combinational 4-bit to 8-bit active-low decoder, instantiated 4 times.
- Expected size: about 200 lines of RTL.

## Test plan
- Hold, then release:
  - Stimulus: reset, then key_valid with code 4'h7 on 5 consecutive scans, then 3 quiet scan_ticks, then code 4'h7 again.
  - Required response: digit_cnt 0→1→2, entry=16'h0077, and only two digits accepted.
- Operand commit:
  - Stimulus: enter 1,2,A,F then enter; then 0,0,3 then enter.
  - Required response: num1=16'h12AF, phase=ENTER_B, then num2=16'h0003, one operands_valid pulse, phase=DONE, out_7seg=all-lit digits 0,0,0,3.
- Overflow: enter 5 digits 1,2,3,4,5.
  - Required response: entry=16'h1234, digit_cnt=4, and the 5th digit has no effect.
- Clear paths:
  - Clear with 2 digits in ENTER_B → count 0, state stays ENTER_B.
  - A second clear → ENTER_A.
  - Clear in DONE → num1=num2=0.
- Simultaneity:
  - enter and clear edges in the same cycle → clear applied, no commit.
  - key_valid and scan_tick in the same cycle while locked → release counter reset to 0.
- Reset:
  - enter_btn held high through reset release → no commit.
  - rst_n pulled low mid-entry → all outputs at reset values at the next edge, out_7seg=32'hFFFF_FFFF.
